// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: frames a byte stream onto GMII with preamble/SFD, zero padding, CRC-32 FCS and inter-frame gap.
module gmii_tx_framer #(
  parameter int MIN_BYTES = 60,
  parameter int MAX_BYTES = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic       GMII_GTXCLK,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] GMII_TXD,
  output logic       GMII_TXEN,
  output logic       GMII_TXER,
  output logic       frame_done,
  output logic       err_pulse
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;
  localparam logic [10:0] MIN_L = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_L = 11'(MAX_BYTES);
  localparam logic [15:0] IFG_L = 16'(IFG_BYTES - 1);
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] aux_q, aux_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0] txd_q, txd_d;
  logic txen_q, txen_d, txer_q, txer_d, done_q, done_d, err_q, err_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign cnt_inc = cnt_q + 11'd1;
  assign s_ready = state_q == DATA;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aux_d   = aux_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        aux_d = '0;
        crc_d = '1;
        if (s_valid) begin
          state_d = PREAMBLE;
          txd_d   = 8'h55;
          txen_d  = 1'b1;
        end
      end
      PREAMBLE: begin
        txen_d  = 1'b1;
        txd_d   = (aux_q == 16'd6) ? 8'hD5 : 8'h55;
        aux_d   = (aux_q == 16'd6) ? 16'd0 : aux_q + 16'd1;
        state_d = (aux_q == 16'd6) ? DATA : PREAMBLE;
      end
      DATA: begin
        txen_d = 1'b1;
        if (s_valid) begin
          txd_d = s_data;
          crc_d = crc_byte(crc_q, s_data);
          cnt_d = cnt_inc;
          if (s_last || cnt_inc == MAX_L) begin
            state_d = (cnt_inc < MIN_L) ? PAD : FCS;
            err_d   = !s_last;
          end
        end else begin
          // underrun: poison the frame and abandon it without an FCS
          txer_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IFG;
        end
      end
      PAD: begin
        txen_d  = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        cnt_d   = cnt_inc;
        state_d = (cnt_inc >= MIN_L) ? FCS : PAD;
      end
      FCS: begin
        txen_d  = 1'b1;
        txd_d   = ~crc_q[7:0];
        crc_d   = crc_q >> 8;
        aux_d   = (aux_q == 16'd3) ? 16'd0 : aux_q + 16'd1;
        state_d = (aux_q == 16'd3) ? IFG : FCS;
      end
      IFG: begin
        // txer_q still marks an underrun byte on the first gap edge
        done_d  = (aux_q == 16'd0) && !txer_q;
        aux_d   = aux_q + 16'd1;
        state_d = (aux_q == IFG_L) ? IDLE : IFG;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aux_q   <= '0;
      crc_q   <= '1;
      txd_q   <= '0;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aux_q   <= aux_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign GMII_TXD   = txd_q;
  assign GMII_TXEN  = txen_q;
  assign GMII_TXER  = txer_q;
  assign frame_done = done_q;
  assign err_pulse  = err_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: random and directed frames checked by a byte/frame scoreboard against a CRC reference model.
module tb_gmii_tx_framer;
  localparam int MIN_B = 60;
  localparam int MAX_B = 1514;
  localparam int IFG_B = 12;
  typedef struct {logic [7:0] d; logic er;} byte_t;
  typedef struct {int len; int gap; bit done; int err;} frm_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic s_ready, txen, txer, frame_done, err_pulse;
  logic [7:0] txd;
  int tests = 0, fails = 0;
  bit ignore = 1'b0;
  byte_t exp_q[$];
  frm_t frm_q[$];
  logic [7:0] pl[$];
  gmii_tx_framer #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B), .IFG_BYTES(IFG_B)) dut (
    .GMII_GTXCLK(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .GMII_TXD(txd), .GMII_TXEN(txen), .GMII_TXER(txer),
    .frame_done(frame_done), .err_pulse(err_pulse));
  always #4 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // MSB-first form of the IEEE CRC-32 on bit-reversed bytes, then reflected back
  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] c, r;
    logic [7:0] rb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      rb = {<<{b[i]}};
      c ^= {rb, 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? (c << 1) ^ 32'h04C11DB7 : c << 1;
    end
    r = {<<{c}};
    return ~r;
  endfunction
  task automatic push_frame(input int mode, input int gap);
    logic [7:0] body[$];
    logic [31:0] c;
    body = pl;
    for (int i = 0; i < 7; i++) exp_q.push_back('{d: 8'h55, er: 1'b0});
    exp_q.push_back('{d: 8'hD5, er: 1'b0});
    if (mode == 1) begin
      foreach (pl[i]) exp_q.push_back('{d: pl[i], er: 1'b0});
      exp_q.push_back('{d: 8'h00, er: 1'b1});
      frm_q.push_back('{len: 9 + pl.size(), gap: gap, done: 1'b0, err: 1});
    end else begin
      while (body.size() < MIN_B) body.push_back(8'h00);
      foreach (body[i]) exp_q.push_back('{d: body[i], er: 1'b0});
      c = model_crc(body);
      for (int k = 0; k < 4; k++) exp_q.push_back('{d: c[8*k +: 8], er: 1'b0});
      frm_q.push_back('{len: 12 + body.size(), gap: gap, done: 1'b1, err: (mode == 2) ? 1 : 0});
    end
  endtask
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    while (!s_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask
  task automatic send_frame(input int mode, input int gap);
    push_frame(mode, gap);
    if (mode == 1) begin
      foreach (pl[i]) send_byte(pl[i], 1'b0);
      s_valid = 1'b0;
      @(negedge clk);
    end else if (mode == 2) begin
      foreach (pl[i]) send_byte(pl[i], 1'b0);
      s_data = 8'hAB; s_last = 1'b0;
      for (int i = 0; i < 10; i++) begin chk("ready_after_max", s_ready, 0); @(negedge clk); end
    end else
      foreach (pl[i]) send_byte(pl[i], i == pl.size() - 1);
  endtask
  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || frm_q.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    chk("drain", exp_q.size() + frm_q.size(), 0);
  endtask
  int run_len = 0, idle_len = 0, err_seen = 0;
  bit prev_en = 1'b0;
  logic [7:0] rx[$];
  always @(negedge clk) begin
    byte_t e;
    frm_t f;
    logic [7:0] pay[$];
    if (txen) begin
      if (!prev_en) begin
        if (!ignore) begin
          if (frm_q.size() == 0) chk("unexpected_frame", 1, 0);
          else if (frm_q[0].gap >= 0) chk("ifg_exact", idle_len, frm_q[0].gap);
          else chk("ifg_min", idle_len >= IFG_B, 1);
        end
        run_len = 0; err_seen = 0; rx.delete();
      end
      run_len++;
      rx.push_back(txd);
      if (err_pulse) err_seen++;
      if (!ignore) begin
        if (exp_q.size() == 0) chk("extra_byte", txd, 0);
        else begin
          e = exp_q.pop_front();
          chk("txd", txd, e.d);
          chk("txer", txer, e.er);
        end
      end
      idle_len = 0;
    end else begin
      if (prev_en && !ignore && frm_q.size() != 0) begin
        f = frm_q.pop_front();
        chk("txen_len", run_len, f.len);
        chk("frame_done", frame_done, f.done);
        chk("err_count", err_seen, f.err);
        if (f.done) begin
          pay = rx[8:$];
          chk("fcs_residue", model_crc(pay), 32'h2144DF1C);
        end
      end else if (frame_done) chk("stray_done", 1, 0);
      if (err_pulse) chk("stray_err", 1, 0);
      if (txer) chk("stray_txer", 1, 0);
      idle_len++;
    end
    prev_en = txen;
  end
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_txd", txd, 0);
    chk("rst_txen", txen, 0);
    chk("rst_txer", txer, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err_pulse, 0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    send_frame(0, -1);
    rand_pl(60);
    send_frame(0, IFG_B);
    rand_pl(64);
    send_frame(0, IFG_B);
    rand_pl(64);
    send_frame(0, IFG_B);
    for (int f = 0; f < 8; f++) begin
      rand_pl($urandom_range(1, 130));
      send_frame(0, IFG_B);
    end
    rand_pl(20);
    send_frame(1, IFG_B);
    rand_pl($urandom_range(1, 80));
    send_frame(0, IFG_B);
    rand_pl(MAX_B);
    send_frame(2, IFG_B);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    rand_pl(70);
    send_frame(0, -1);
    drain();
    ignore = 1'b1;
    rand_pl(40);
    for (int i = 0; i < 30; i++) send_byte(pl[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txen", txen, 0);
    chk("midrst_txd", txd, 0);
    chk("midrst_ready", s_ready, 0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    ignore = 1'b0;
    rand_pl(60);
    send_frame(0, -1);
    drain();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
